// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master shared by NUM_REQ requesters: one LSB-first full-duplex transfer per grant.
// Optional macro SPI_ARB_LOOPBACK_EN adds a loopback input that samples MOSI instead of MISO.
module spi_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
`ifdef SPI_ARB_LOOPBACK_EN
    input  logic                      loopback,
`endif
    input  logic                      MISO,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      SCLK,
    output logic [NUM_REQ-1:0]        CS,
    output logic                      MOSI
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   txShift_q, txShift_d;
    logic [DATA_W-1:0]   rxShift_q, rxShift_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       win_q, win_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cntLast;
    logic                sampleBit;
    logic                pickValid;
    logic [PW-1:0]       pickIdx;
    int                  candIdx;

`ifdef SPI_ARB_LOOPBACK_EN
    logic lb_q, lb_d;
    assign sampleBit = lb_q ? txShift_q[0] : MISO;
`else
    assign sampleBit = MISO;
`endif

    assign cntLast = (cnt_q == CW'(CLK_DIV - 1));

    // Scan downward so the set bit closest above the pointer is the last one written.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        candIdx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            candIdx = int'(ptr_q) + i;
            if (candIdx >= NUM_REQ) candIdx = candIdx - NUM_REQ;
            if (req[PW'(candIdx)]) begin
                pickValid = 1'b1;
                pickIdx   = PW'(candIdx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rx_d      = rx_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        grant_d   = grant_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_ARB_LOOPBACK_EN
        lb_d      = lb_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pickValid) begin
                    state_d          = SETUP;
                    win_d            = pickIdx;
                    grant_d          = '0;
                    grant_d[pickIdx] = 1'b1;
                    cs_d             = ~grant_d;
                    busy_d           = 1'b1;
                    txShift_d        = tx_data[pickIdx*DATA_W +: DATA_W];
                    rxShift_d        = '0;
`ifdef SPI_ARB_LOOPBACK_EN
                    lb_d             = loopback;
`endif
                end
            end
            SETUP: begin
                if (cntLast) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (!cntLast) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    // phase 0 is the low half of a bit period, phase 1 the high half.
                    if (!phase_q) begin
                        phase_d          = 1'b1;
                        sclk_d           = 1'b1;
                        rxShift_d[bit_q] = sampleBit;
                    end else if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_d     = bit_q + BW'(1);
                        txShift_d = txShift_q >> 1;
                        phase_d   = 1'b0;
                        sclk_d    = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (cntLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                    cs_d    = '1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = rxShift_q;
                    ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + PW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rx_q      <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            grant_q   <= '0;
            cs_q      <= '1;
            sclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_ARB_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rx_q      <= rx_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_ARB_LOOPBACK_EN
            lb_q      <= lb_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign SCLK    = sclk_q;
    assign CS      = cs_q;
    assign MOSI    = busy_q & txShift_q[0];

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed sequence with random bytes, an LSB-first slave model
// and a round-robin reference model working from the arbitration rules.
module tb_spi_master_arbiter;

    localparam int N = 4;
    localparam int D = 2;
    localparam int W = 8;
    localparam logic [N-1:0] ALL1 = '1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] tx_data = '0;
    logic           MISO = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           done;
    logic [W-1:0]   rx_data;
    logic           SCLK;
    logic [N-1:0]   CS;
    logic           MOSI;
`ifdef SPI_ARB_LOOPBACK_EN
    logic           loopback = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int refPtr = 0;
    int doneCount = 0;

    logic [W-1:0] slaveTx = '0;
    logic [W-1:0] slaveRx = '0;
    int fallCnt = 0;
    int riseCnt = 0;

    always #5 clk = ~clk;

    spi_master_arbiter #(.NUM_REQ(N), .CLK_DIV(D), .DATA_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .tx_data(tx_data),
`ifdef SPI_ARB_LOOPBACK_EN
        .loopback(loopback),
`endif
        .MISO(MISO),
        .grant(grant),
        .busy(busy),
        .done(done),
        .rx_data(rx_data),
        .SCLK(SCLK),
        .CS(CS),
        .MOSI(MOSI)
    );

    // Slave model: shifts its byte out LSB first on falling SCLK, captures MOSI on rising SCLK.
    always @(negedge SCLK) begin
        if (CS != ALL1) begin
            if (fallCnt < W) MISO = slaveTx[fallCnt];
            fallCnt++;
        end
    end

    always @(posedge SCLK) begin
        if (CS != ALL1) begin
            if (riseCnt < W) slaveRx[riseCnt] = MOSI;
            riseCnt++;
        end
    end

    function automatic int pickWinner(input int ptr, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstCs", CS, ALL1);
        checkOutput("rstSclk", SCLK, 1);
        checkOutput("rstMosi", MOSI, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRx", rx_data, 0);
        reset = 1'b0;
        refPtr = 0;
    endtask

    // One complete transfer; starts at most one cycle after a done pulse or reset release.
    task automatic applyStimulus(input logic [N-1:0] reqPat, input logic [N-1:0] reqLater,
                                 input logic lb, input logic useFixed,
                                 input logic [W-1:0] fixTx, input logic [W-1:0] fixMiso);
        int win;
        int elapsed;
        int waitCyc;
        logic [W-1:0] txByte;
        logic [W-1:0] expRx;
        logic [N-1:0] expGrant;
        logic [N-1:0] expCs;
        win = pickWinner(refPtr, reqPat);
        expGrant = '0;
        expGrant[win] = 1'b1;
        expCs = ~expGrant;
        tx_data = $urandom;
        slaveTx = W'($urandom);
        if (useFixed) begin
            tx_data[win*W +: W] = fixTx;
            slaveTx = fixMiso;
        end
        txByte = tx_data[win*W +: W];
`ifdef SPI_ARB_LOOPBACK_EN
        loopback = lb;
        expRx = lb ? txByte : slaveTx;
`else
        expRx = slaveTx;
`endif
        req = reqPat;
        fallCnt = 0;
        riseCnt = 0;
        slaveRx = '0;
        @(posedge clk);
        #1;
        checkOutput("donePulseEnd", done, 0);
        waitCyc = 0;
        while (grant === '0 && waitCyc < 8) begin
            checkOutput("idleCs", CS, ALL1);
            checkOutput("idleSclk", SCLK, 1);
            @(posedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("grantWinner", grant, expGrant);
        elapsed = 0;
        while (done !== 1'b1 && elapsed < 18*D + 8) begin
            checkOutput("grantHeld", grant, expGrant);
            checkOutput("csLow", CS, expCs);
            checkOutput("busyHigh", busy, 1);
            if (elapsed == 3) tx_data = ~tx_data;
            if (elapsed == 8*D) req = reqLater;
            @(posedge clk);
            #1;
            elapsed++;
        end
        checkOutput("xferLength", elapsed, 18*D);
        checkOutput("donePulse", done, 1);
        checkOutput("endGrant", grant, 0);
        checkOutput("endCs", CS, ALL1);
        checkOutput("endBusy", busy, 0);
        checkOutput("endSclk", SCLK, 1);
        checkOutput("endMosi", MOSI, 0);
        checkOutput("rxData", rx_data, expRx);
        checkOutput("slaveRx", slaveRx, txByte);
        checkOutput("sclkRises", riseCnt, W);
        if (done === 1'b1) doneCount++;
        refPtr = (win + 1) % N;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startDone;
        int waitCyc;
        int win;
        logic [N-1:0] expGrant;
        logic [N-1:0] r;
        logic [N-1:0] later;

        doReset();

        // Single transfer with fixed bytes.
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1, 8'b1010_0101, 8'b0010_0111);

        // Simultaneous requests right after reset: 0 then 2.
        doReset();
        applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b0, '0, '0);
        applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b0, '0, '0);
        checkOutput("simulPtr", refPtr, 3);

        // Fairness: all requesting for five transfers.
        doReset();
        startDone = doneCount;
        repeat (5) applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, '0, '0);
        checkOutput("fairDoneCount", doneCount - startDone, 5);

        // Reset during bit 4 of a transfer that the pointer gives to requester 3.
        win = pickWinner(refPtr, 4'b1001);
        expGrant = '0;
        expGrant[win] = 1'b1;
        req = 4'b1001;
        tx_data = $urandom;
        slaveTx = W'($urandom);
        fallCnt = 0;
        riseCnt = 0;
        waitCyc = 0;
        @(posedge clk);
        #1;
        while (grant === '0 && waitCyc < 8) begin
            @(posedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("abortGrant", grant, expGrant);
        waitCyc = 0;
        while (fallCnt < 5 && waitCyc < 18*D + 8) begin
            @(posedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("abortReachedBit4", fallCnt, 5);
        reset = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        checkOutput("abortSclk", SCLK, 1);
        checkOutput("abortCs", CS, ALL1);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortGrantClr", grant, 0);
        checkOutput("abortDone", done, 0);
        reset = 1'b0;
        refPtr = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("abortNoDone", done, 0);
            checkOutput("abortIdleSclk", SCLK, 1);
        end
        applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b0, '0, '0);

        // Request dropped during SHIFT still completes.
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, '0, '0);

        // Random request patterns and mid-transfer request changes.
        repeat (6) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            later = N'($urandom);
            applyStimulus(r, later, 1'b0, 1'b0, '0, '0);
        end

`ifdef SPI_ARB_LOOPBACK_EN
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b1, 8'h3C, 8'hFF);
        checkOutput("loopbackRx", rx_data, 8'h3C);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, '0, '0);
`endif

        req = '0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
